// File: rtl/variable_latency_credit_xbar.sv
// Credit-limited request/response crossbar with per-port round-robin arbitration
// and optional single-cycle pipeline stages on the request and response outputs.
module variable_latency_credit_xbar #(
    parameter int NumIn          = 4,
    parameter int NumOut         = 6,
    parameter int ReqDataWidth   = 32,
    parameter int RespDataWidth  = 32,
    parameter int MaxOutstanding = 4,
    parameter bit SpillReq       = 1'b0,
    parameter bit SpillResp      = 1'b0,
    localparam int TgtW = (NumOut > 1) ? $clog2(NumOut) : 1,
    localparam int IniW = (NumIn > 1) ? $clog2(NumIn) : 1,
    localparam int CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumIn-1:0]                       req_valid_i,
    output logic [NumIn-1:0]                       req_ready_o,
    input  logic [NumIn-1:0][TgtW-1:0]             req_tgt_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]     req_data_i,
    output logic [NumIn-1:0]                       resp_valid_o,
    input  logic [NumIn-1:0]                       resp_ready_i,
    output logic [NumIn-1:0][RespDataWidth-1:0]    resp_data_o,
    output logic [NumOut-1:0]                      req_valid_o,
    input  logic [NumOut-1:0]                      req_ready_i,
    output logic [NumOut-1:0][IniW-1:0]            req_ini_addr_o,
    output logic [NumOut-1:0][ReqDataWidth-1:0]    req_data_o,
    input  logic [NumOut-1:0]                      resp_valid_i,
    output logic [NumOut-1:0]                      resp_ready_o,
    input  logic [NumOut-1:0][IniW-1:0]            resp_ini_addr_i,
    input  logic [NumOut-1:0][RespDataWidth-1:0]   resp_data_i,
    output logic [NumIn-1:0][CntW-1:0]             outstanding_o,
    output logic                                   tgt_err_o
);

    logic [NumOut-1:0][NumIn-1:0]  req_elig_s;
    logic [NumOut-1:0][IniW-1:0]   req_gnt_s;
    logic [NumOut-1:0]             req_any_s;
    logic [NumOut-1:0]             req_stage_rdy_s;
    logic [NumOut-1:0][IniW-1:0]   req_ptr_r;
    logic [NumIn-1:0][NumOut-1:0]  rsp_elig_s;
    logic [NumIn-1:0][TgtW-1:0]    rsp_gnt_s;
    logic [NumIn-1:0]              rsp_any_s;
    logic [NumIn-1:0]              rsp_stage_rdy_s;
    logic [NumIn-1:0][TgtW-1:0]    rsp_ptr_r;
    logic [NumIn-1:0][CntW-1:0]    cnt_r;
    logic [NumIn-1:0]              req_hs_s;
    logic [NumIn-1:0]              rsp_hs_s;
    logic                          bad_tgt_s;
    logic                          tgt_err_r;

    function automatic int wrap_idx(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

    // Request side: eligibility, per-target round-robin pick, initiator ready
    always_comb begin
        req_elig_s  = '0;
        req_gnt_s   = '0;
        req_any_s   = '0;
        req_ready_o = '0;
        bad_tgt_s   = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            bad_tgt_s = bad_tgt_s | (req_valid_i[i] && (int'(req_tgt_i[i]) >= NumOut));
        end
        for (int t = 0; t < NumOut; t++) begin
            for (int i = 0; i < NumIn; i++) begin
                req_elig_s[t][i] = req_valid_i[i] && (int'(req_tgt_i[i]) == t) &&
                                   (cnt_r[i] < CntW'(MaxOutstanding));
            end
            // Scanning downward leaves the first eligible index at/after the pointer
            for (int k = NumIn - 1; k >= 0; k--) begin
                req_any_s[t] = req_any_s[t] | req_elig_s[t][wrap_idx(int'(req_ptr_r[t]), k, NumIn)];
                req_gnt_s[t] = req_elig_s[t][wrap_idx(int'(req_ptr_r[t]), k, NumIn)] ?
                               IniW'(wrap_idx(int'(req_ptr_r[t]), k, NumIn)) : req_gnt_s[t];
            end
            for (int i = 0; i < NumIn; i++) begin
                req_ready_o[i] = req_ready_o[i] |
                    (req_elig_s[t][i] && (req_gnt_s[t] == IniW'(i)) && req_stage_rdy_s[t]);
            end
        end
    end

    // Response side: eligibility, per-initiator round-robin pick, target ready
    always_comb begin
        rsp_elig_s   = '0;
        rsp_gnt_s    = '0;
        rsp_any_s    = '0;
        resp_ready_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            for (int t = 0; t < NumOut; t++) begin
                rsp_elig_s[i][t] = resp_valid_i[t] && (int'(resp_ini_addr_i[t]) == i);
            end
            for (int k = NumOut - 1; k >= 0; k--) begin
                rsp_any_s[i] = rsp_any_s[i] | rsp_elig_s[i][wrap_idx(int'(rsp_ptr_r[i]), k, NumOut)];
                rsp_gnt_s[i] = rsp_elig_s[i][wrap_idx(int'(rsp_ptr_r[i]), k, NumOut)] ?
                               TgtW'(wrap_idx(int'(rsp_ptr_r[i]), k, NumOut)) : rsp_gnt_s[i];
            end
            for (int t = 0; t < NumOut; t++) begin
                resp_ready_o[t] = resp_ready_o[t] |
                    (rsp_elig_s[i][t] && (rsp_gnt_s[i] == TgtW'(t)) && rsp_stage_rdy_s[i]);
            end
        end
    end

    // Round-robin pointers advance past the winner only on an accepted transfer
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_ptr_r <= '0;
            rsp_ptr_r <= '0;
        end else begin
            for (int t = 0; t < NumOut; t++) begin
                if (req_any_s[t] && req_stage_rdy_s[t]) begin
                    req_ptr_r[t] <= IniW'((int'(req_gnt_s[t]) + 1) % NumIn);
                end else begin
                    req_ptr_r[t] <= req_ptr_r[t];
                end
            end
            for (int i = 0; i < NumIn; i++) begin
                if (rsp_any_s[i] && rsp_stage_rdy_s[i]) begin
                    rsp_ptr_r[i] <= TgtW'((int'(rsp_gnt_s[i]) + 1) % NumOut);
                end else begin
                    rsp_ptr_r[i] <= rsp_ptr_r[i];
                end
            end
        end
    end

    assign req_hs_s = req_valid_i & req_ready_o;
    assign rsp_hs_s = resp_valid_o & resp_ready_i;

    // Saturating in-flight counters, both ends counted at the initiator boundary
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r     <= '0;
            tgt_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NumIn; i++) begin
                if (req_hs_s[i] && !rsp_hs_s[i] && (cnt_r[i] != CntW'(MaxOutstanding))) begin
                    cnt_r[i] <= cnt_r[i] + CntW'(1);
                end else if (!req_hs_s[i] && rsp_hs_s[i] && (cnt_r[i] != CntW'(0))) begin
                    cnt_r[i] <= cnt_r[i] - CntW'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
            tgt_err_r <= tgt_err_r | bad_tgt_s;
        end
    end

    assign outstanding_o = cnt_r;
    assign tgt_err_o     = tgt_err_r;

    for (genvar t = 0; t < NumOut; t++) begin : g_req_out
        if (SpillReq) begin : g_spill
            logic                    v_r;
            logic [IniW-1:0]         a_r;
            logic [ReqDataWidth-1:0] d_r;
            assign req_stage_rdy_s[t] = !v_r || req_ready_i[t];
            // Pipeline stage: reloads whenever empty or drained this cycle
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    v_r <= 1'b0;
                    a_r <= '0;
                    d_r <= '0;
                end else if (req_stage_rdy_s[t]) begin
                    v_r <= req_any_s[t];
                    a_r <= req_gnt_s[t];
                    d_r <= req_data_i[req_gnt_s[t]];
                end else begin
                    v_r <= v_r;
                    a_r <= a_r;
                    d_r <= d_r;
                end
            end
            assign req_valid_o[t]    = v_r;
            assign req_ini_addr_o[t] = a_r;
            assign req_data_o[t]     = d_r;
        end else begin : g_comb
            assign req_stage_rdy_s[t] = req_ready_i[t];
            assign req_valid_o[t]     = req_any_s[t];
            assign req_ini_addr_o[t]  = req_gnt_s[t];
            assign req_data_o[t]      = req_data_i[req_gnt_s[t]];
        end
    end

    for (genvar i = 0; i < NumIn; i++) begin : g_rsp_out
        if (SpillResp) begin : g_spill
            logic                     v_r;
            logic [RespDataWidth-1:0] d_r;
            assign rsp_stage_rdy_s[i] = !v_r || resp_ready_i[i];
            // Pipeline stage for the response delivered to this initiator
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    v_r <= 1'b0;
                    d_r <= '0;
                end else if (rsp_stage_rdy_s[i]) begin
                    v_r <= rsp_any_s[i];
                    d_r <= resp_data_i[rsp_gnt_s[i]];
                end else begin
                    v_r <= v_r;
                    d_r <= d_r;
                end
            end
            assign resp_valid_o[i] = v_r;
            assign resp_data_o[i]  = d_r;
        end else begin : g_comb
            assign rsp_stage_rdy_s[i] = resp_ready_i[i];
            assign resp_valid_o[i]    = rsp_any_s[i];
            assign resp_data_o[i]     = resp_data_i[rsp_gnt_s[i]];
        end
    end

endmodule

// File: tb/tb_variable_latency_credit_xbar.sv
// Directed bench: instance "a" is combinational with MaxOutstanding=2,
// instance "b" has both pipeline stages enabled and default cap.
module tb_variable_latency_credit_xbar;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [3:0]        a_req_valid_i, a_req_ready_o, a_resp_valid_o, a_resp_ready_i;
    logic [3:0][2:0]   a_req_tgt_i;
    logic [3:0][31:0]  a_req_data_i, a_resp_data_o;
    logic [5:0]        a_req_valid_o, a_req_ready_i, a_resp_valid_i, a_resp_ready_o;
    logic [5:0][1:0]   a_req_ini_addr_o, a_resp_ini_addr_i;
    logic [5:0][31:0]  a_req_data_o, a_resp_data_i;
    logic [3:0][1:0]   a_outstanding_o;
    logic              a_tgt_err_o;

    logic [3:0]        b_req_valid_i, b_req_ready_o, b_resp_valid_o, b_resp_ready_i;
    logic [3:0][2:0]   b_req_tgt_i;
    logic [3:0][31:0]  b_req_data_i, b_resp_data_o;
    logic [5:0]        b_req_valid_o, b_req_ready_i, b_resp_valid_i, b_resp_ready_o;
    logic [5:0][1:0]   b_req_ini_addr_o, b_resp_ini_addr_i;
    logic [5:0][31:0]  b_req_data_o, b_resp_data_i;
    logic [3:0][2:0]   b_outstanding_o;
    logic              b_tgt_err_o;

    variable_latency_credit_xbar #(.MaxOutstanding(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid_i), .req_ready_o(a_req_ready_o), .req_tgt_i(a_req_tgt_i),
        .req_data_i(a_req_data_i), .resp_valid_o(a_resp_valid_o), .resp_ready_i(a_resp_ready_i),
        .resp_data_o(a_resp_data_o), .req_valid_o(a_req_valid_o), .req_ready_i(a_req_ready_i),
        .req_ini_addr_o(a_req_ini_addr_o), .req_data_o(a_req_data_o),
        .resp_valid_i(a_resp_valid_i), .resp_ready_o(a_resp_ready_o),
        .resp_ini_addr_i(a_resp_ini_addr_i), .resp_data_i(a_resp_data_i),
        .outstanding_o(a_outstanding_o), .tgt_err_o(a_tgt_err_o)
    );

    variable_latency_credit_xbar #(.SpillReq(1'b1), .SpillResp(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid_i), .req_ready_o(b_req_ready_o), .req_tgt_i(b_req_tgt_i),
        .req_data_i(b_req_data_i), .resp_valid_o(b_resp_valid_o), .resp_ready_i(b_resp_ready_i),
        .resp_data_o(b_resp_data_o), .req_valid_o(b_req_valid_o), .req_ready_i(b_req_ready_i),
        .req_ini_addr_o(b_req_ini_addr_o), .req_data_o(b_req_data_o),
        .resp_valid_i(b_resp_valid_i), .resp_ready_o(b_resp_ready_o),
        .resp_ini_addr_i(b_resp_ini_addr_i), .resp_data_i(b_resp_data_i),
        .outstanding_o(b_outstanding_o), .tgt_err_o(b_tgt_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        a_req_valid_i = '0; a_req_tgt_i = '0; a_req_data_i = '0; a_resp_ready_i = '0;
        a_req_ready_i = '0; a_resp_valid_i = '0; a_resp_ini_addr_i = '0; a_resp_data_i = '0;
        b_req_valid_i = '0; b_req_tgt_i = '0; b_req_data_i = '0; b_resp_ready_i = '0;
        b_req_ready_i = '0; b_resp_valid_i = '0; b_resp_ini_addr_i = '0; b_resp_data_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_req_valid_o, a_resp_valid_o, a_outstanding_o, a_tgt_err_o} !== 19'h0) begin
            errors++;
            $display("FAIL reset_a: got %0h expected 0", {a_req_valid_o, a_resp_valid_o, a_outstanding_o, a_tgt_err_o});
        end
        checks++;
        if ({b_req_valid_o, b_resp_valid_o, b_outstanding_o, b_tgt_err_o} !== 23'h0) begin
            errors++;
            $display("FAIL reset_b: got %0h expected 0", {b_req_valid_o, b_resp_valid_o, b_outstanding_o, b_tgt_err_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        a_req_ready_i = '1;
        a_resp_ready_i = '1;
        for (int i = 0; i < 3; i++) begin
            a_req_valid_i[i] = 1'b1;
            a_req_tgt_i[i]   = 3'd3;
            a_req_data_i[i]  = 32'hA0 + i;
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (a_req_valid_o[3] !== 1'b1 || a_req_ini_addr_o[3] !== 2'(c) || a_req_data_o[3] !== 32'hA0 + c) begin
                errors++;
                $display("FAIL rr_grant%0d: got v=%b ini=%0d d=%0h expected v=1 ini=%0d d=%0h",
                         c, a_req_valid_o[3], a_req_ini_addr_o[3], a_req_data_o[3], c, 32'hA0 + c);
            end
            checks++;
            if (a_req_ready_o !== (4'b0001 << c)) begin
                errors++;
                $display("FAIL rr_ready%0d: got %b expected %b", c, a_req_ready_o, 4'b0001 << c);
            end
            @(posedge clk);
            @(negedge clk);
            a_req_valid_i[c] = 1'b0;
        end
        #1;
        checks++;
        if (a_outstanding_o !== {2'd0, 2'd1, 2'd1, 2'd1}) begin
            errors++;
            $display("FAIL rr_count: got %0h expected 15", a_outstanding_o);
        end
        for (int c = 0; c < 3; c++) begin
            a_resp_valid_i[3]    = 1'b1;
            a_resp_ini_addr_i[3] = 2'(c);
            a_resp_data_i[3]     = 32'hB0 + c;
            #1;
            checks++;
            if (a_resp_valid_o !== (4'b0001 << c) || a_resp_data_o[c] !== 32'hB0 + c || a_resp_ready_o !== 6'b001000) begin
                errors++;
                $display("FAIL rsp_route%0d: got v=%b d=%0h rdy=%b expected v=%b d=%0h rdy=001000",
                         c, a_resp_valid_o, a_resp_data_o[c], a_resp_ready_o, 4'b0001 << c, 32'hB0 + c);
            end
            @(posedge clk);
            @(negedge clk);
        end
        a_resp_valid_i = '0;
        #1;
        checks++;
        if (a_outstanding_o !== 8'h0) begin
            errors++;
            $display("FAIL rr_drain: got %0h expected 0", a_outstanding_o);
        end
    endtask

    task automatic test_resp_arbitration();
        int exp_t [3] = '{4, 1, 4};
        a_resp_valid_i[1] = 1'b1; a_resp_ini_addr_i[1] = 2'd1; a_resp_data_i[1] = 32'hC1;
        a_resp_valid_i[4] = 1'b1; a_resp_ini_addr_i[4] = 2'd1; a_resp_data_i[4] = 32'hC4;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (a_resp_valid_o[1] !== 1'b1 || a_resp_data_o[1] !== ((exp_t[c] == 4) ? 32'hC4 : 32'hC1) ||
                a_resp_ready_o !== (6'b000001 << exp_t[c])) begin
                errors++;
                $display("FAIL rsp_rr%0d: got d=%0h rdy=%b expected from target %0d", c,
                         a_resp_data_o[1], a_resp_ready_o, exp_t[c]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (a_outstanding_o[1] !== 2'd0) begin
                errors++;
                $display("FAIL rsp_at_zero%0d: got %0d expected 0", c, a_outstanding_o[1]);
            end
            @(negedge clk);
        end
        a_resp_valid_i = '0;
    endtask

    task automatic test_outstanding_cap();
        a_req_valid_i[0] = 1'b1;
        a_req_tgt_i[0]   = 3'd0;
        for (int k = 0; k < 2; k++) begin
            a_req_data_i[0] = 32'hD0 + k;
            #1;
            checks++;
            if (a_req_ready_o[0] !== 1'b1 || a_req_data_o[0] !== 32'hD0 + k) begin
                errors++;
                $display("FAIL cap_accept%0d: got rdy=%b d=%0h expected rdy=1 d=%0h", k,
                         a_req_ready_o[0], a_req_data_o[0], 32'hD0 + k);
            end
            @(posedge clk);
            #1;
            checks++;
            if (a_outstanding_o[0] !== 2'(k + 1)) begin
                errors++;
                $display("FAIL cap_count%0d: got %0d expected %0d", k, a_outstanding_o[0], k + 1);
            end
            @(negedge clk);
        end
        a_req_data_i[0] = 32'hD2;
        #1;
        checks++;
        if (a_req_ready_o[0] !== 1'b0 || a_req_valid_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL cap_stall: got rdy=%b tv=%b expected 0 0", a_req_ready_o[0], a_req_valid_o[0]);
        end
        @(posedge clk);
        @(negedge clk);
        a_resp_valid_i[0] = 1'b1; a_resp_ini_addr_i[0] = 2'd0; a_resp_data_i[0] = 32'hE0;
        #1;
        checks++;
        if (a_req_ready_o[0] !== 1'b0 || a_resp_valid_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL cap_resp: got rdy=%b rv=%b expected 0 1", a_req_ready_o[0], a_resp_valid_o[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_outstanding_o[0] !== 2'd1) begin
            errors++;
            $display("FAIL cap_release: got %0d expected 1", a_outstanding_o[0]);
        end
        @(negedge clk);
        a_resp_valid_i[0] = 1'b0;
        #1;
        checks++;
        if (a_req_ready_o[0] !== 1'b1 || a_req_data_o[0] !== 32'hD2) begin
            errors++;
            $display("FAIL cap_third: got rdy=%b d=%0h expected 1 d2", a_req_ready_o[0], a_req_data_o[0]);
        end
        @(posedge clk);
        @(negedge clk);
        a_req_valid_i[0] = 1'b0;
        a_resp_valid_i[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_outstanding_o[0] !== 2'd0) begin
            errors++;
            $display("FAIL cap_drain: got %0d expected 0", a_outstanding_o[0]);
        end
        @(negedge clk);
        a_resp_valid_i[0] = 1'b0;
    endtask

    task automatic test_simultaneous();
        a_req_valid_i[1] = 1'b1; a_req_tgt_i[1] = 3'd2; a_req_data_i[1] = 32'hF0;
        @(posedge clk);
        @(negedge clk);
        a_req_data_i[1] = 32'hF1;
        a_resp_valid_i[5] = 1'b1; a_resp_ini_addr_i[5] = 2'd1; a_resp_data_i[5] = 32'hF5;
        #1;
        checks++;
        if (a_outstanding_o[1] !== 2'd1 || a_req_ready_o[1] !== 1'b1 || a_resp_valid_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL sim_setup: got cnt=%0d rdy=%b rv=%b expected 1 1 1",
                     a_outstanding_o[1], a_req_ready_o[1], a_resp_valid_o[1]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_outstanding_o[1] !== 2'd1) begin
            errors++;
            $display("FAIL sim_hold: got %0d expected 1", a_outstanding_o[1]);
        end
        @(negedge clk);
        a_req_valid_i[1] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_outstanding_o[1] !== 2'd0) begin
            errors++;
            $display("FAIL sim_drain: got %0d expected 0", a_outstanding_o[1]);
        end
        @(negedge clk);
        a_resp_valid_i = '0;
    endtask

    task automatic test_bad_target();
        a_req_valid_i[2] = 1'b1; a_req_tgt_i[2] = 3'd7; a_req_data_i[2] = 32'h77;
        #1;
        checks++;
        if (a_tgt_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_early: got %b expected 0", a_tgt_err_o);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (a_req_ready_o[2] !== 1'b0 || a_req_valid_o !== 6'b0) begin
                errors++;
                $display("FAIL err_nogrant%0d: got rdy=%b tv=%b expected 0 000000", c, a_req_ready_o[2], a_req_valid_o);
            end
            @(posedge clk);
            #1;
            checks++;
            if (a_tgt_err_o !== 1'b1) begin
                errors++;
                $display("FAIL err_set%0d: got %b expected 1", c, a_tgt_err_o);
            end
            @(negedge clk);
            #1;
        end
        a_req_valid_i[2] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_tgt_err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", a_tgt_err_o);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_tgt_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", a_tgt_err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        b_req_ready_i = '1;
        b_resp_ready_i = '1;
        for (int k = 0; k < 10; k++) begin
            b_req_valid_i[0] = (k < 8);
            b_req_tgt_i[0]   = 3'd0;
            b_req_data_i[0]  = 32'h5000 + k;
            b_resp_valid_i[5]    = (k >= 1 && k <= 8);
            b_resp_ini_addr_i[5] = 2'd0;
            b_resp_data_i[5]     = 32'h6000 + k;
            #1;
            checks++;
            if (b_req_ready_o[0] !== (k < 8) || b_req_valid_o[0] !== (k >= 1 && k <= 8)) begin
                errors++;
                $display("FAIL b2b_hs%0d: got rdy=%b tv=%b", k, b_req_ready_o[0], b_req_valid_o[0]);
            end
            if (k >= 1 && k <= 8) begin
                checks++;
                if (b_req_data_o[0] !== 32'h5000 + k - 1 || b_req_ini_addr_o[0] !== 2'd0) begin
                    errors++;
                    $display("FAIL b2b_req%0d: got d=%0h ini=%0d expected d=%0h ini=0", k,
                             b_req_data_o[0], b_req_ini_addr_o[0], 32'h5000 + k - 1);
                end
            end
            checks++;
            if (b_resp_valid_o[0] !== (k >= 2) ||
                ((k >= 2) && b_resp_data_o[0] !== 32'h6000 + k - 1)) begin
                errors++;
                $display("FAIL b2b_rsp%0d: got v=%b d=%0h expected d=%0h", k,
                         b_resp_valid_o[0], b_resp_data_o[0], 32'h6000 + k - 1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        b_resp_valid_i = '0;
        #1;
        checks++;
        if (b_outstanding_o !== 12'h0 || b_resp_valid_o !== 4'h0) begin
            errors++;
            $display("FAIL b2b_end: got cnt=%0h rv=%b expected 0 0", b_outstanding_o, b_resp_valid_o);
        end
    endtask

    task automatic test_stall_hold();
        b_req_valid_i[0] = 1'b1; b_req_tgt_i[0] = 3'd0; b_req_data_i[0] = 32'h7000;
        b_req_ready_i[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_req_ready_i[0] = 1'b0;
        b_req_data_i[0]  = 32'h7001;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (b_req_valid_o[0] !== 1'b1 || b_req_data_o[0] !== 32'h7000 || b_req_ready_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: got v=%b d=%0h rdy=%b expected 1 7000 0", c,
                         b_req_valid_o[0], b_req_data_o[0], b_req_ready_o[0]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        b_req_ready_i[0] = 1'b1;
        #1;
        checks++;
        if (b_req_data_o[0] !== 32'h7000 || b_req_ready_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got d=%0h rdy=%b expected 7000 1", b_req_data_o[0], b_req_ready_o[0]);
        end
        @(posedge clk);
        @(negedge clk);
        b_req_valid_i[0] = 1'b0;
        b_req_ready_i[0] = 1'b0;
        #1;
        checks++;
        if (b_req_valid_o[0] !== 1'b1 || b_req_data_o[0] !== 32'h7001) begin
            errors++;
            $display("FAIL hold_next: got v=%b d=%0h expected 1 7001", b_req_valid_o[0], b_req_data_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (b_req_valid_o !== 6'b0 || b_outstanding_o !== 12'h0 || a_outstanding_o !== 8'h0) begin
            errors++;
            $display("FAIL mid_reset: got tv=%b cnt=%0h expected 0 0", b_req_valid_o, b_outstanding_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b_req_ready_i[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (b_req_valid_o !== 6'b0) begin
            errors++;
            $display("FAIL no_replay: got %b expected 000000", b_req_valid_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_resp_arbitration();
        test_outstanding_cap();
        test_simultaneous();
        test_bad_target();
        test_back_to_back();
        test_stall_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/variable_latency_credit_xbar.md
VARIABLE_LATENCY_CREDIT_XBAR -- requirements
Module: variable_latency_credit_xbar

Interface
REQ-001 SHALL have parameter NumIn, default 4, meaning number of initiators (any value >= 1; power of two not required).
REQ-002 SHALL have parameter NumOut, default 6, meaning number of targets (any value >= 1).
REQ-003 SHALL have parameter ReqDataWidth, default 32, meaning request payload width.
REQ-004 SHALL have parameter RespDataWidth, default 32, meaning response payload width.
REQ-005 SHALL have parameter MaxOutstanding, default 4, meaning per-initiator cap on in-flight requests (>= 1).
REQ-006 SHALL have parameter SpillReq, default 1'b0; when set, a spill register is inserted at each target request output.
REQ-007 SHALL have parameter SpillResp, default 1'b0; when set, a spill register is inserted at each initiator response output.
REQ-008 SHALL derive TgtW = max(1,$clog2(NumOut)), IniW = max(1,$clog2(NumIn)) and CntW = $clog2(MaxOutstanding+1).
REQ-009 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-010 rst_ni  in  1  reset, synchronous and active-low.
REQ-011 req_valid_i / req_ready_o  in/out  [NumIn]  initiator request handshake.
REQ-012 req_tgt_i  in  [NumIn][TgtW]  target index of each request.
REQ-013 req_data_i  in  [NumIn][ReqDataWidth]  request payload.
REQ-014 resp_valid_o / resp_ready_i  out/in  [NumIn]  initiator response handshake.
REQ-015 resp_data_o  out  [NumIn][RespDataWidth]  response payload.
REQ-016 req_valid_o / req_ready_i  out/in  [NumOut]  target request handshake.
REQ-017 req_ini_addr_o  out  [NumOut][IniW]  index of the originating initiator.
REQ-018 req_data_o  out  [NumOut][ReqDataWidth]  routed request payload.
REQ-019 resp_valid_i / resp_ready_o  in/out  [NumOut]  target response handshake.
REQ-020 resp_ini_addr_i  in  [NumOut][IniW]  destination initiator of each response.
REQ-021 resp_data_i  in  [NumOut][RespDataWidth]  response payload.
REQ-022 outstanding_o  out  [NumIn][CntW]  current in-flight count per initiator.
REQ-023 tgt_err_o  out  1  sticky flag: a valid request named a target index >= NumOut.

Function
REQ-024 Each target SHALL arbitrate among initiators that are valid, addressing it, and below the cap, using round-robin with a per-target pointer.
REQ-025 The grant SHALL go to the first eligible initiator at or after the pointer, wrapping modulo NumIn; after a target-side handshake the pointer SHALL become grant+1 mod NumIn; the pointer SHALL hold without a handshake.
REQ-026 Each initiator SHALL arbitrate among targets returning responses to it in the same round-robin manner, with a per-initiator pointer modulo NumOut.
REQ-027 A valid request SHALL hold req_ready_o low while outstanding_o of its initiator equals MaxOutstanding.
REQ-028 outstanding_o SHALL increment on a request handshake at the initiator side, decrement on a response handshake at the initiator side, and hold when both or neither occur in the same cycle.
REQ-029 The counter SHALL never wrap; a response handshake at count 0 SHALL leave the count at 0.
REQ-030 A request with req_tgt_i >= NumOut SHALL never be granted (req_ready_o low), and SHALL set tgt_err_o from the next cycle until reset.
REQ-031 With SpillReq=0, the request path SHALL be combinational (zero latency); with SpillReq=1, the latency SHALL be exactly 1 cycle at full throughput (one transfer per cycle, no bubbles under constant ready).
REQ-032 The response path SHALL apply REQ-031 with SpillResp in place of SpillReq.
REQ-033 Payloads and handshake signals SHALL remain stable while valid is high and ready is low, at every output.
REQ-034 Non-granted requests and responses SHALL see ready low; no payload SHALL be duplicated or dropped.
REQ-035 NumIn=1 or NumOut=1 SHALL degenerate correctly (the index output is tied to 0; arbitration becomes trivial).

Reset
REQ-036 While rst_ni is low at a clock edge, all round-robin pointers, outstanding counters, spill registers and tgt_err_o SHALL clear to 0 at that edge; all valid outputs SHALL be 0 on the following cycle.
REQ-037 A reset asserted mid-transfer SHALL discard in-flight spill contents, with no replay after release.

Verification
REQ-038 Default parameters; initiators 0,1,2 all request target 3 with ready held high for 3 cycles -> grants 0,1,2 in order, req_ini_addr_o[3] = 0,1,2.
REQ-039 MaxOutstanding=2; initiator 0 issues 3 requests with no responses -> the first 2 are accepted, the third is stalled, outstanding_o[0]=2; one response is then accepted -> the count returns to 1 and the third request is accepted on the next cycle.
REQ-040 Same cycle: request handshake and response handshake on initiator 1 at count 1 -> the count stays 1.
REQ-041 NumOut=6; req_tgt_i[2]=7 is valid -> req_ready_o[2]=0 indefinitely and tgt_err_o=1 from the next cycle; after reset tgt_err_o=0.
REQ-042 SpillReq=1, SpillResp=1, a stream of 8 back-to-back requests from initiator 0 to target 0 with ready high -> each appears exactly 1 cycle later with no bubbles; toggling req_ready_i[0] holds the data stable.
REQ-043 rst_ni is pulsed low while a spill register holds data -> req_valid_o=0 the next cycle, and all outstanding_o=0.
